// File: rtl/iig_bank_scheduler_if.sv
// Bus bundle between the bank scheduler, the IIG write stream, the two BRAM
// banks and the two Haar-window classifiers.
interface iig_bank_scheduler_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 21
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              overrun;
  logic              we_bank0;
  logic              we_bank1;
  logic [ADDR_W-1:0] waddr_bank;
  logic [DATA_W-1:0] wdata_bank;
  logic              frame_avail;
  logic [1:0]        rd_req;
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic              rd_done;
  logic [1:0]        rd_gnt;
  logic [ADDR_W-1:0] rd_addr_bank;
  logic [DATA_W-1:0] q_bank0;
  logic [DATA_W-1:0] q_bank1;
  logic [1:0]        rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr0, rd_addr1, rd_done,
           q_bank0, q_bank1,
    output wr_ready, overrun, we_bank0, we_bank1, waddr_bank, wdata_bank,
           frame_avail, rd_gnt, rd_addr_bank, rd_valid, rd_data
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr0, rd_addr1, rd_done,
           q_bank0, q_bank1,
    input  wr_ready, overrun, we_bank0, we_bank1, waddr_bank, wdata_bank,
           frame_avail, rd_gnt, rd_addr_bank, rd_valid, rd_data
  );
endinterface

// File: rtl/iig_bank_scheduler.sv
// Ping-pong scheduler for the two integral-image banks: routes IIG writes to the
// bank being filled and round-robins the shared read port between two classifiers.
module iig_bank_scheduler #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 21,
  parameter int FRAME_WORDS = 4800
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  iig_bank_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    WRITING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  // Encoding 3 is never produced; if it ever appears it decays to EMPTY.
  function automatic bank_state_t legal_state(input logic [1:0] s);
    case (s)
      2'd1:    return WRITING;
      2'd2:    return FULL;
      default: return EMPTY;
    endcase
  endfunction

  logic [1:0]        state_q [2];
  bank_state_t       st      [2];
  bank_state_t       state_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              rr_last_q, rr_last_d;

  logic              we0_q, we0_d;
  logic              we1_q, we1_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              overrun_q, overrun_d;

  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        vld_p0, vld_p0_d;
  logic              bsel_p0, bsel_p0_d;
  logic [1:0]        vld_p1, vld_p1_d;
  logic              bsel_p1, bsel_p1_d;

  logic              wr_oth;
  logic              wr_ready;
  logic              frame_avail;
  logic              accept;
  logic              last_wr;
  logic              release_rd;
  logic              any_writing;
  logic              claim;
  logic [1:0]        gnt;

  always_comb begin
    for (int i = 0; i < 2; i++) st[i] = legal_state(state_q[i]);
  end

  assign wr_oth      = ~wr_ptr_q;
  assign wr_ready    = (st[wr_ptr_q] == WRITING);
  assign frame_avail = (st[rd_ptr_q] == FULL);
  assign accept      = bus.wr_valid & wr_ready;
  assign last_wr     = accept & (bus.wr_addr == LAST_ADDR);
  assign release_rd  = bus.rd_done & frame_avail;
  assign any_writing = (st[0] == WRITING) | (st[1] == WRITING);
  // A writer stalled on a just-released bank picks it up one cycle later.
  assign claim       = ~any_writing & (st[wr_ptr_q] == EMPTY);

  always_comb begin
    gnt = 2'b00;
    if (frame_avail && run) begin
      case (bus.rd_req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_d[0] = st[0];
    state_d[1] = st[1];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rr_last_d  = rr_last_q;
    we0_d      = 1'b0;
    we1_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    overrun_d  = bus.wr_valid & ~wr_ready;
    rd_addr_d  = rd_addr_q;
    vld_p0_d   = gnt;
    bsel_p0_d  = rd_ptr_q;
    vld_p1_d   = vld_p0;
    bsel_p1_d  = bsel_p0;

    if (accept) begin
      we0_d   = ~wr_ptr_q;
      we1_d   = wr_ptr_q;
      waddr_d = bus.wr_addr;
      wdata_d = bus.wr_data;
    end

    if (last_wr) begin
      state_d[wr_ptr_q] = FULL;
      wr_ptr_d          = wr_oth;
      if (st[wr_oth] == EMPTY) state_d[wr_oth] = WRITING;
    end

    if (release_rd) begin
      state_d[rd_ptr_q] = EMPTY;
      rd_ptr_d          = ~rd_ptr_q;
    end

    if (claim) state_d[wr_ptr_q] = WRITING;

    if (|gnt) begin
      rd_addr_d = gnt[1] ? bus.rd_addr1 : bus.rd_addr0;
      rr_last_d = gnt[1];
    end

    if (!run) begin
      state_d[0] = WRITING;
      state_d[1] = EMPTY;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      rr_last_d  = 1'b1;
      we0_d      = 1'b0;
      we1_d      = 1'b0;
      waddr_d    = '0;
      wdata_d    = '0;
      overrun_d  = 1'b0;
      rd_addr_d  = '0;
      vld_p0_d   = 2'b00;
      bsel_p0_d  = 1'b0;
      vld_p1_d   = 2'b00;
      bsel_p1_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= WRITING;
      state_q[1] <= EMPTY;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rr_last_q  <= 1'b1;
      we0_q      <= 1'b0;
      we1_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      overrun_q  <= 1'b0;
      rd_addr_q  <= '0;
      vld_p0     <= 2'b00;
      bsel_p0    <= 1'b0;
      vld_p1     <= 2'b00;
      bsel_p1    <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rr_last_q  <= rr_last_d;
      we0_q      <= we0_d;
      we1_q      <= we1_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      overrun_q  <= overrun_d;
      // stage p0: address to BRAM, bank select and requester id captured
      rd_addr_q  <= rd_addr_d;
      vld_p0     <= vld_p0_d;
      bsel_p0    <= bsel_p0_d;
      // stage p1: BRAM data arrives alongside these
      vld_p1     <= vld_p1_d;
      bsel_p1    <= bsel_p1_d;
    end
  end

  assign bus.wr_ready     = wr_ready;
  assign bus.overrun      = overrun_q;
  assign bus.we_bank0     = we0_q;
  assign bus.we_bank1     = we1_q;
  assign bus.waddr_bank   = waddr_q;
  assign bus.wdata_bank   = wdata_q;
  assign bus.frame_avail  = frame_avail;
  assign bus.rd_gnt       = gnt;
  assign bus.rd_addr_bank = rd_addr_q;
  assign bus.rd_valid     = vld_p1;
  assign bus.rd_data      = (|vld_p1) ? (bsel_p1 ? bus.q_bank1 : bus.q_bank0) : '0;

endmodule

// File: tb/tb_iig_bank_scheduler.sv
// Directed bench for iig_bank_scheduler with two behavioural 1-cycle-latency BRAM banks.
module tb_iig_bank_scheduler;

  localparam int AW = 13;
  localparam int DW = 21;
  localparam int FW = 4800;

  logic clk;
  logic rst_n;
  logic run;
  int   checks;
  int   errors;

  logic [DW-1:0] mem0 [FW];
  logic [DW-1:0] mem1 [FW];

  iig_bank_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  iig_bank_scheduler #(.ADDR_W(AW), .DATA_W(DW), .FRAME_WORDS(FW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ifc.we_bank0) mem0[ifc.waddr_bank] <= ifc.wdata_bank;
    if (ifc.we_bank1) mem1[ifc.waddr_bank] <= ifc.wdata_bank;
    ifc.q_bank0 <= mem0[ifc.rd_addr_bank];
    ifc.q_bank1 <= mem1[ifc.rd_addr_bank];
  end

  function automatic logic [DW-1:0] word(input int a, input logic [DW-1:0] base);
    return (a == 100) ? 21'h1ABCD : base + DW'(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_words(input int first, input int last_a, input logic [DW-1:0] base);
    for (int a = first; a <= last_a; a++) begin
      ifc.wr_valid = 1'b1;
      ifc.wr_addr  = AW'(a);
      ifc.wr_data  = word(a, base);
      tick();
    end
    ifc.wr_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n        = 1'b0;
    run          = 1'b1;
    ifc.wr_valid = 1'b0;
    ifc.wr_addr  = '0;
    ifc.wr_data  = '0;
    ifc.rd_req   = 2'b00;
    ifc.rd_addr0 = '0;
    ifc.rd_addr1 = '0;
    ifc.rd_done  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    checks++; if (ifc.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %0h want 1", ifc.wr_ready); end
    checks++; if ({ifc.we_bank0, ifc.we_bank1} !== 2'b00) begin errors++; $display("FAIL reset_we got %b want 00", {ifc.we_bank0, ifc.we_bank1}); end
    checks++; if (ifc.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0h want 0", ifc.overrun); end
    checks++; if (ifc.frame_avail !== 1'b0) begin errors++; $display("FAIL reset_frame_avail got %0h want 0", ifc.frame_avail); end
    checks++; if (ifc.rd_valid !== 2'b00) begin errors++; $display("FAIL reset_rd_valid got %b want 00", ifc.rd_valid); end
    checks++; if (ifc.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", ifc.rd_data); end
    checks++; if (ifc.rd_addr_bank !== '0) begin errors++; $display("FAIL reset_rd_addr got %0d want 0", ifc.rd_addr_bank); end
  endtask

  task automatic test_fill_bank0();
    int bad_rdy;
    int bad_we;
    bad_rdy = 0;
    bad_we  = 0;
    for (int a = 0; a < FW; a++) begin
      ifc.wr_valid = 1'b1;
      ifc.wr_addr  = AW'(a);
      ifc.wr_data  = word(a, '0);
      #1;
      if (ifc.wr_ready !== 1'b1) bad_rdy++;
      tick();
      if (ifc.we_bank0 !== 1'b1 || ifc.we_bank1 !== 1'b0 ||
          ifc.waddr_bank !== AW'(a) || ifc.wdata_bank !== word(a, '0)) bad_we++;
    end
    ifc.wr_valid = 1'b0;
    checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL fill0_wr_ready bad cycles %0d want 0", bad_rdy); end
    checks++; if (bad_we !== 0) begin errors++; $display("FAIL fill0_we_bank0 bad cycles %0d want 0", bad_we); end
    #1;
    checks++; if (ifc.frame_avail !== 1'b1) begin errors++; $display("FAIL fill0_frame_avail got %0h want 1", ifc.frame_avail); end
    checks++; if (ifc.wr_ready !== 1'b1) begin errors++; $display("FAIL fill0_bank1_writing got %0h want 1", ifc.wr_ready); end
    tick();
    checks++; if ({ifc.we_bank0, ifc.we_bank1} !== 2'b00) begin errors++; $display("FAIL fill0_idle_we got %b want 00", {ifc.we_bank0, ifc.we_bank1}); end
  endtask

  task automatic test_read_single();
    ifc.rd_req   = 2'b10;
    ifc.rd_addr1 = AW'(100);
    #1;
    checks++; if (ifc.rd_gnt !== 2'b10) begin errors++; $display("FAIL single_gnt got %b want 10", ifc.rd_gnt); end
    tick();
    ifc.rd_req = 2'b00;
    checks++; if (ifc.rd_addr_bank !== AW'(100)) begin errors++; $display("FAIL single_rd_addr got %0d want 100", ifc.rd_addr_bank); end
    checks++; if (ifc.rd_valid !== 2'b00) begin errors++; $display("FAIL single_valid_n1 got %b want 00", ifc.rd_valid); end
    tick();
    checks++; if (ifc.rd_valid !== 2'b10) begin errors++; $display("FAIL single_valid_n2 got %b want 10", ifc.rd_valid); end
    checks++; if (ifc.rd_data !== 21'h1ABCD) begin errors++; $display("FAIL single_rd_data got %h want 1abcd", ifc.rd_data); end
    tick();
    checks++; if (ifc.rd_valid !== 2'b00) begin errors++; $display("FAIL single_valid_n3 got %b want 00", ifc.rd_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0]    exp_g [4];
    logic [DW-1:0] exp_d;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        ifc.rd_req   = 2'b11;
        ifc.rd_addr0 = AW'(10 + i);
        ifc.rd_addr1 = AW'(20 + i);
      end else begin
        ifc.rd_req = 2'b00;
      end
      #1;
      if (i < 4) begin
        checks++; if (ifc.rd_gnt !== exp_g[i]) begin errors++; $display("FAIL rr_gnt%0d got %b want %b", i, ifc.rd_gnt, exp_g[i]); end
      end
      if (i >= 2) begin
        exp_d = (exp_g[i-2] == 2'b01) ? DW'(10 + i - 2) : DW'(20 + i - 2);
        checks++; if (ifc.rd_valid !== exp_g[i-2]) begin errors++; $display("FAIL rr_valid%0d got %b want %b", i - 2, ifc.rd_valid, exp_g[i-2]); end
        checks++; if (ifc.rd_data !== exp_d) begin errors++; $display("FAIL rr_data%0d got %h want %h", i - 2, ifc.rd_data, exp_d); end
      end
      tick();
    end
  endtask

  task automatic test_overrun_release();
    int bad_we;
    bad_we = 0;
    for (int a = 0; a < FW; a++) begin
      ifc.wr_valid = 1'b1;
      ifc.wr_addr  = AW'(a);
      ifc.wr_data  = word(a, 21'h80000);
      tick();
      if (ifc.we_bank1 !== 1'b1 || ifc.we_bank0 !== 1'b0) bad_we++;
    end
    ifc.wr_valid = 1'b0;
    checks++; if (bad_we !== 0) begin errors++; $display("FAIL fill1_we_bank1 bad cycles %0d want 0", bad_we); end
    #1;
    checks++; if (ifc.wr_ready !== 1'b0) begin errors++; $display("FAIL both_full_wr_ready got %0h want 0", ifc.wr_ready); end
    ifc.wr_valid = 1'b1;
    ifc.wr_addr  = AW'(5);
    ifc.wr_data  = 21'h55;
    tick();
    ifc.wr_valid = 1'b0;
    checks++; if (ifc.overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse got %0h want 1", ifc.overrun); end
    checks++; if ({ifc.we_bank0, ifc.we_bank1} !== 2'b00) begin errors++; $display("FAIL overrun_dropped got %b want 00", {ifc.we_bank0, ifc.we_bank1}); end
    tick();
    checks++; if (ifc.overrun !== 1'b0) begin errors++; $display("FAIL overrun_width got %0h want 0", ifc.overrun); end
    ifc.rd_done = 1'b1;
    tick();
    ifc.rd_done = 1'b0;
    #1;
    checks++; if (ifc.wr_ready !== 1'b0) begin errors++; $display("FAIL release_n1_wr_ready got %0h want 0", ifc.wr_ready); end
    checks++; if (ifc.frame_avail !== 1'b1) begin errors++; $display("FAIL release_bank1_avail got %0h want 1", ifc.frame_avail); end
    tick();
    checks++; if (ifc.wr_ready !== 1'b1) begin errors++; $display("FAIL release_n2_wr_ready got %0h want 1", ifc.wr_ready); end
    ifc.wr_valid = 1'b1;
    ifc.wr_addr  = AW'(7);
    ifc.wr_data  = 21'h777;
    tick();
    ifc.wr_valid = 1'b0;
    checks++; if ({ifc.we_bank0, ifc.we_bank1} !== 2'b10) begin errors++; $display("FAIL release_write_bank0 got %b want 10", {ifc.we_bank0, ifc.we_bank1}); end
    checks++; if (ifc.waddr_bank !== AW'(7)) begin errors++; $display("FAIL release_waddr got %0d want 7", ifc.waddr_bank); end
  endtask

  task automatic test_last_write_and_done();
    drive_words(0, FW - 2, '0);
    ifc.wr_valid = 1'b1;
    ifc.wr_addr  = AW'(FW - 1);
    ifc.wr_data  = word(FW - 1, '0);
    ifc.rd_done  = 1'b1;
    #1;
    checks++; if (ifc.wr_ready !== 1'b1) begin errors++; $display("FAIL coinc_pre_wr_ready got %0h want 1", ifc.wr_ready); end
    tick();
    ifc.wr_valid = 1'b0;
    ifc.rd_done  = 1'b0;
    checks++; if (ifc.we_bank0 !== 1'b1) begin errors++; $display("FAIL coinc_last_we0 got %0h want 1", ifc.we_bank0); end
    checks++; if (ifc.overrun !== 1'b0) begin errors++; $display("FAIL coinc_overrun got %0h want 0", ifc.overrun); end
    checks++; if (ifc.frame_avail !== 1'b1) begin errors++; $display("FAIL coinc_bank0_avail got %0h want 1", ifc.frame_avail); end
    checks++; if (ifc.wr_ready !== 1'b0) begin errors++; $display("FAIL coinc_n1_wr_ready got %0h want 0", ifc.wr_ready); end
    tick();
    checks++; if (ifc.wr_ready !== 1'b1) begin errors++; $display("FAIL coinc_n2_wr_ready got %0h want 1", ifc.wr_ready); end
    ifc.wr_valid = 1'b1;
    ifc.wr_addr  = AW'(3);
    ifc.wr_data  = 21'h333;
    tick();
    ifc.wr_valid = 1'b0;
    checks++; if ({ifc.we_bank0, ifc.we_bank1} !== 2'b01) begin errors++; $display("FAIL coinc_write_bank1 got %b want 01", {ifc.we_bank0, ifc.we_bank1}); end
  endtask

  task automatic test_run_clear();
    drive_words(4, 5, '0);
    ifc.rd_req   = 2'b01;
    ifc.rd_addr0 = AW'(4);
    tick();
    run        = 1'b0;
    ifc.rd_req = 2'b11;
    tick();
    checks++; if (ifc.wr_ready !== 1'b1) begin errors++; $display("FAIL clear_wr_ready got %0h want 1", ifc.wr_ready); end
    checks++; if ({ifc.we_bank0, ifc.we_bank1} !== 2'b00) begin errors++; $display("FAIL clear_we got %b want 00", {ifc.we_bank0, ifc.we_bank1}); end
    checks++; if (ifc.waddr_bank !== '0 || ifc.wdata_bank !== '0) begin errors++; $display("FAIL clear_wbus got %0d/%h want 0/0", ifc.waddr_bank, ifc.wdata_bank); end
    checks++; if (ifc.frame_avail !== 1'b0) begin errors++; $display("FAIL clear_frame_avail got %0h want 0", ifc.frame_avail); end
    checks++; if (ifc.rd_gnt !== 2'b00) begin errors++; $display("FAIL clear_gnt got %b want 00", ifc.rd_gnt); end
    checks++; if (ifc.rd_valid !== 2'b00) begin errors++; $display("FAIL clear_rd_valid got %b want 00", ifc.rd_valid); end
    checks++; if (ifc.rd_addr_bank !== '0) begin errors++; $display("FAIL clear_rd_addr got %0d want 0", ifc.rd_addr_bank); end
    run        = 1'b1;
    ifc.rd_req = 2'b00;
    tick();
    checks++; if (ifc.rd_valid !== 2'b00) begin errors++; $display("FAIL clear_after_rd_valid got %b want 00", ifc.rd_valid); end
    checks++; if (ifc.rd_data !== '0) begin errors++; $display("FAIL clear_after_rd_data got %h want 0", ifc.rd_data); end
  endtask

  task automatic test_async_reset();
    drive_words(0, FW - 1, 21'h40000);
    ifc.rd_req   = 2'b01;
    ifc.rd_addr0 = AW'(50);
    tick();
    ifc.rd_req = 2'b00;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (ifc.rd_addr_bank !== '0) begin errors++; $display("FAIL areset_rd_addr got %0d want 0", ifc.rd_addr_bank); end
    checks++; if (ifc.frame_avail !== 1'b0) begin errors++; $display("FAIL areset_frame_avail got %0h want 0", ifc.frame_avail); end
    checks++; if (ifc.wr_ready !== 1'b1) begin errors++; $display("FAIL areset_wr_ready got %0h want 1", ifc.wr_ready); end
    checks++; if (ifc.rd_valid !== 2'b00) begin errors++; $display("FAIL areset_rd_valid got %b want 00", ifc.rd_valid); end
    tick();
    checks++; if (ifc.rd_valid !== 2'b00) begin errors++; $display("FAIL areset_after_rd_valid got %b want 00", ifc.rd_valid); end
    checks++; if ({ifc.we_bank0, ifc.we_bank1, ifc.overrun} !== 3'b000) begin errors++; $display("FAIL areset_wctl got %b want 000", {ifc.we_bank0, ifc.we_bank1, ifc.overrun}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    apply_reset();
    test_reset();
    test_fill_bank0();
    test_read_single();
    test_round_robin();
    test_overrun_release();
    test_last_write_and_done();
    test_run_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iig_bank_scheduler.md
Name: iig_bank_scheduler

Overview:
- Ping-pong scheduler for the two integral-image BRAM banks (each 80x60 = 4800 words) that sit between the IIG datapath and the Haar-window classifiers.
- IIG always writes one bank while the classifiers read the other, previously completed bank.
- The block owns bank state (EMPTY/WRITING/FULL) and routes write traffic to the correct bank.
- It arbitrates the single BRAM read port between two classifier requesters with round-robin.

Parameters:
ADDR_W, 13, BRAM address width
DATA_W, 21, integral-image word width (80*60*255 fits in 21 bits)
FRAME_WORDS, 4800, words per frame; the last address is FRAME_WORDS-1

Ports:
iClk  in  1  clock
iReset_n  in  1  asynchronous active-low reset
iRun  in  1  low = synchronous clear of all state (same as reset values)
iWr_valid  in  1  IIG output word valid (driven by IIG oOutput_ready)
iWr_addr  in  ADDR_W  IIG write address
iWr_data  in  DATA_W  IIG write data
oWr_ready  out  1  a bank is in WRITING; IIG may present data
oOverrun  out  1  1-cycle pulse: iWr_valid while oWr_ready low
oWe_BANK0  out  1  bank0 write enable
oWe_BANK1  out  1  bank1 write enable
oWaddr_BANK  out  ADDR_W  shared write address to both banks
oWdata_BANK  out  DATA_W  shared write data to both banks
oFrame_avail  out  1  the read bank is FULL
iRd_req  in  2  per-classifier read request
iRd_addr0  in  ADDR_W  classifier 0 address
iRd_addr1  in  ADDR_W  classifier 1 address
iRd_done  in  1  1-cycle pulse: classifiers finished the current frame
oRd_gnt  out  2  one-hot grant, combinational
oRd_addr_BANK  out  ADDR_W  registered read address to both banks
iQ_BANK0  in  DATA_W  bank0 read data (1-cycle BRAM latency)
iQ_BANK1  in  DATA_W  bank1 read data
oRd_valid  out  2  per-classifier data-valid
oRd_data  out  DATA_W  read data, muxed by the pipelined bank select

Behaviour:
- Reset or ~iRun:
  - bank0 = WRITING, bank1 = EMPTY; wr_ptr = 0, rd_ptr = 0; rr_last = 1 (classifier 0 wins the first tie).
  - All outputs 0 except oWr_ready = 1.
- Bank states are 2-bit per bank: EMPTY, WRITING, FULL.
  - wr_ptr and rd_ptr toggle, so banks are written and consumed strictly alternately.
- Write path:
  - oWr_ready = (state[wr_ptr] == WRITING).
  - When iWr_valid & oWr_ready, the next edge registers oWaddr_BANK/oWdata_BANK and oWe_BANK[wr_ptr] = 1. Latency is 1 cycle.
  - Otherwise both oWe are 0 next cycle and addr/data hold.
- End of frame: an accepted write with iWr_addr == FRAME_WORDS-1 causes, at that edge:
  - state[wr_ptr] <= FULL and wr_ptr toggles.
  - If the other bank is EMPTY, it becomes WRITING in the same edge (no bubble).
  - Otherwise oWr_ready drops until that bank is released.
- Overrun: iWr_valid & ~oWr_ready pulses oOverrun next cycle. The word is dropped and no bank state changes.
- Read availability: oFrame_avail = (state[rd_ptr] == FULL).
- Arbitration: grants only when oFrame_avail.
  - A single requester gets the grant.
  - If both request, grant the one not equal to rr_last; rr_last updates on every grant.
- Read pipeline:
  - Grant in cycle N → oRd_addr_BANK registered at the end of N from the granted address.
  - Bank select and requester id are pipelined 2 stages.
  - In cycle N+2, oRd_valid[id] = 1 and oRd_data = iQ_BANK[bank_sel_d2].
  - Full throughput is one read per cycle; an ungranted requester holds its request.
- Release: iRd_done while oFrame_avail causes state[rd_ptr] <= EMPTY and rd_ptr toggles.
  - If that bank is the writer's stalled target (wr_ptr == old rd_ptr and no WRITING bank), it becomes WRITING the following cycle.
  - iRd_done while ~oFrame_avail is ignored.
- Simultaneous last-write and iRd_done in the same cycle: both are applied. The freed bank is claimed by the writer no earlier than the next cycle.
- Reads in flight at release: the 2-stage pipeline completes with the old bank select. Data stays valid because the writer cannot write that bank before N+2.
- The 2-bit state encoding uses the value 3 as illegal; it forces EMPTY.

Test Plan:
- Reset, then 4800 writes at addresses 0..4799 → oWe_BANK0 on each accepted cycle; after addr 4799, oFrame_avail = 1, bank1 WRITING, oWr_ready stays 1.
- Write frames 0 and 1 with no iRd_done → oWr_ready = 0 after frame 1; one extra iWr_valid → oOverrun pulses 1 cycle; iRd_done → oWr_ready = 1 two cycles later, writes go to bank0.
- Frame full, iRd_req = 2'b11 held 4 cycles → grants 01,10,01,10; oRd_valid follows each grant by 2 cycles with the matching iQ_BANK0 data.
- Pre-load bank0 addr 100 = 0x1ABCD via writes, then read addr 100 from classifier 1 → oRd_addr_BANK = 100 at N+1; oRd_valid = 2'b10 and oRd_data = 0x1ABCD at N+2.
- Last write (addr 4799) and iRd_done in the same cycle → both banks change state correctly; no oOverrun; next frame writes to the released bank.
- iRun low mid-frame, and separately iReset_n asserted asynchronously mid-read → all outputs return to reset values; oRd_valid is 0 the cycle after.
